// File: rtl/alu_seq.sv
// ALU_SEQ: sequential ALU with a valid/ready request port and a held result.
// Operations: add, sub, and, or, xor, slt, shl complete in one cycle; mul is a
// shift-add multiplier that takes WIDTH cycles.
// Optional feature macro: ALU_SEQ_MUL_EN enables the multiplier. Without it
// op 111 completes in one cycle with out=0 and ovf=1 marking it unsupported.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t             r_state;
    state_t             w_nextState;
    logic               w_accept;

    logic [WIDTH-1:0]   r_out;
    logic [3:0]         r_flags;

    logic [WIDTH:0]     w_sumWide;
    logic [WIDTH:0]     w_diffWide;
    logic               w_lessSigned;
    logic [WIDTH-1:0]   w_aluOut;
    logic               w_aluCarry;
    logic               w_aluOvf;
    logic [3:0]         w_aluFlags;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [SHW-1:0]     r_count;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_prodNext;
    logic               w_mulLast;
`endif

    // A request is taken only while idle; in_ready is the idle indication.
    assign w_accept = in_valid && (r_state == S_IDLE);

    // Single-cycle ALU on the live operands; its result is captured on the
    // accepting edge, so the operands are only needed for that one edge.
    always_comb begin
        w_sumWide    = {1'b0, a} + {1'b0, b};
        w_diffWide   = {1'b0, a} - {1'b0, b};
        w_lessSigned = ($signed(a) < $signed(b));
        w_aluOut     = '0;
        w_aluCarry   = 1'b0;
        w_aluOvf     = 1'b0;
        case (op)
            OP_ADD: begin
                w_aluOut   = w_sumWide[WIDTH-1:0];
                w_aluCarry = w_sumWide[WIDTH];
                w_aluOvf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                             (w_sumWide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_aluOut   = w_diffWide[WIDTH-1:0];
                w_aluCarry = w_diffWide[WIDTH];
                w_aluOvf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                             (w_diffWide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_aluOut = a & b;
            OP_OR:  w_aluOut = a | b;
            OP_XOR: w_aluOut = a ^ b;
            OP_SLT: w_aluOut = {{(WIDTH-1){1'b0}}, w_lessSigned};
            OP_SHL: w_aluOut = a << b[SHW-1:0];
            default: begin
                w_aluOut = '0;
`ifdef ALU_SEQ_MUL_EN
                w_aluOvf = 1'b0;
`else
                w_aluOvf = 1'b1;
`endif
            end
        endcase
        w_aluFlags = {w_aluOut[WIDTH-1], w_aluOvf, w_aluCarry, (w_aluOut == '0)};
    end

`ifdef ALU_SEQ_MUL_EN
    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB of the product register) is set, then shift
    // the whole product right. After WIDTH steps r_prod holds the full a*b.
    always_comb begin
        w_mulSum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prodNext = {w_mulSum, r_prod[WIDTH-1:1]};
        w_mulLast  = (r_count == SHW'(WIDTH-1));
    end
`endif

    // State register; reset wins over acceptance and out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        in_ready    = (r_state == S_IDLE);
        out_valid   = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    w_nextState = (op == OP_MUL) ? S_MUL : S_DONE;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                if (w_mulLast) begin
                    w_nextState = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Result and multiplier datapath; out/flags only change when a new result
    // is produced, so they stay stable for the whole time DONE is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_mcand <= '0;
            r_prod  <= '0;
            r_count <= '0;
`endif
        end else begin
            if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    r_mcand <= a;
                    r_prod  <= {{WIDTH{1'b0}}, b};
                    r_count <= '0;
                end else begin
                    r_out   <= w_aluOut;
                    r_flags <= w_aluFlags;
                end
`else
                r_out   <= w_aluOut;
                r_flags <= w_aluFlags;
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            else if (r_state == S_MUL) begin
                r_prod  <= w_prodNext;
                r_count <= r_count + SHW'(1);
                if (w_mulLast) begin
                    r_out   <= w_prodNext[WIDTH-1:0];
                    r_flags <= {w_prodNext[WIDTH-1],
                                (|w_prodNext[2*WIDTH-1:WIDTH]),
                                1'b0,
                                (w_prodNext[WIDTH-1:0] == '0)};
                end
            end
`endif
        end
    end

    assign out   = r_out;
    assign flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): a table of directed vectors plus
// hand-written sequences for backpressure, idle out_ready and resets.
// Multiplier vectors follow the ALU_SEQ_MUL_EN build setting.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out;
    logic [3:0]    flags;
    logic          out_valid;
    logic          out_ready;

    int compared;
    int mismatched;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] expOut;
        logic [3:0]  expFlags;
        int          expLat;
    } vec_t;

    vec_t vecs[32];
    int   nVec;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vop,
                          input logic [31:0] vout, input logic [3:0] vflags, input int vlat);
        vecs[nVec].a        = va;
        vecs[nVec].b        = vb;
        vecs[nVec].op       = vop;
        vecs[nVec].expOut   = vout;
        vecs[nVec].expFlags = vflags;
        vecs[nVec].expLat   = vlat;
        nVec++;
    endtask

    // Issue one request from IDLE, wait for the result, check it and release it.
    task automatic applyStimulus(input int idx);
        int lat;
        int busy;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        op       = vecs[idx].op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat  = 0;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            tick();
            lat++;
        end
        if (!in_ready) busy++;
        checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(vecs[idx].expLat));
        checkOutput($sformatf("v%0d_out", idx), 64'(out), 64'(vecs[idx].expOut));
        checkOutput($sformatf("v%0d_flags", idx), 64'(flags), 64'(vecs[idx].expFlags));
        checkOutput($sformatf("v%0d_busy", idx), 64'(busy), 64'(vecs[idx].expLat + 1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput($sformatf("v%0d_valid_clr", idx), 64'(out_valid), 64'd0);
        checkOutput($sformatf("v%0d_ready_back", idx), 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit sawValid;
        compared   = 0;
        mismatched = 0;
        nVec       = 0;

        addVec(32'd5,        32'd6,        3'b000, 32'd11,       4'b0000, 0);
        addVec(32'd5,        32'd6,        3'b001, 32'hFFFFFFFF, 4'b1010, 0);
        addVec(32'd8,        32'd0,        3'b010, 32'd0,        4'b0001, 0);
        addVec(32'd8,        32'd0,        3'b011, 32'd8,        4'b0000, 0);
        addVec(32'd8,        32'd0,        3'b101, 32'd0,        4'b0001, 0);
        addVec(32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b1100, 0);
        addVec(32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        4'b0011, 0);
        addVec(32'h80000000, 32'h80000000, 3'b000, 32'd0,        4'b0111, 0);
        addVec(32'h80000000, 32'd1,        3'b001, 32'h7FFFFFFF, 4'b0100, 0);
        addVec(32'd3,        32'd3,        3'b001, 32'd0,        4'b0001, 0);
        addVec(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h0FF00FF0, 4'b0000, 0);
        addVec(32'hFFFF0000, 32'h0FF0FFFF, 3'b010, 32'h0FF00000, 4'b0000, 0);
        addVec(32'h80000000, 32'd1,        3'b011, 32'h80000001, 4'b1000, 0);
        addVec(32'hFFFFFFFF, 32'd1,        3'b101, 32'd1,        4'b0000, 0);
        addVec(32'd1,        32'hFFFFFFFF, 3'b101, 32'd0,        4'b0001, 0);
        addVec(32'd1,        32'd31,       3'b110, 32'h80000000, 4'b1000, 0);
        addVec(32'd3,        32'h21,       3'b110, 32'd6,        4'b0000, 0);
        addVec(32'd1,        32'd32,       3'b110, 32'd1,        4'b0000, 0);
`ifdef ALU_SEQ_MUL_EN
        addVec(32'd10,       32'd5,        3'b111, 32'd50,       4'b0000, 32);
        addVec(32'h10000,    32'h10000,    3'b111, 32'd0,        4'b0101, 32);
        addVec(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'd1,        4'b0100, 32);
        addVec(32'h12345,    32'd0,        3'b111, 32'd0,        4'b0001, 32);
`else
        addVec(32'd10,       32'd5,        3'b111, 32'd0,        4'b0101, 0);
        addVec(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'd0,        4'b0101, 0);
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) tick();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out", 64'(out), 64'd0);
        checkOutput("reset_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < nVec; i++) begin
            applyStimulus(i);
        end

        // Backpressure: result held for 5 cycles while a new request waits.
        a = 32'h7FFFFFFF; b = 32'd1; op = 3'b000; in_valid = 1'b1;
        tick();
        a = 32'd1; b = 32'd1; op = 3'b000;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp_out_%0d", i), 64'(out), 64'h80000000);
            checkOutput($sformatf("bp_flags_%0d", i), 64'(flags), 64'b1100);
            checkOutput($sformatf("bp_ready_%0d", i), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_valid_clr", 64'(out_valid), 64'd0);
        checkOutput("bp_out_kept", 64'(out), 64'h80000000);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_held_req_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_held_req_out", 64'(out), 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // out_ready while idle does nothing.
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        checkOutput("idle_ordy_valid", 64'(out_valid), 64'd0);
        checkOutput("idle_ordy_out", 64'(out), 64'd2);
        checkOutput("idle_ordy_ready", 64'(in_ready), 64'd1);

        // Reset beats acceptance on the same edge.
        a = 32'd7; b = 32'd7; op = 3'b000; in_valid = 1'b1; rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        checkOutput("rst_prio_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_prio_out", 64'(out), 64'd0);
        tick();
        checkOutput("rst_prio_valid2", 64'(out_valid), 64'd0);

        // Reset while DONE is held drops the result.
        a = 32'd5; b = 32'd6; op = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("rst_done_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        checkOutput("rst_done_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_done_out", 64'(out), 64'd0);
        checkOutput("rst_done_flags", 64'(flags), 64'd0);
        checkOutput("rst_done_ready", 64'(in_ready), 64'd1);

`ifdef ALU_SEQ_MUL_EN
        // Reset ten cycles into a multiply aborts it without a result.
        a = 32'd10; b = 32'd5; op = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        checkOutput("rst_mul_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_mul_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_mul_out", 64'(out), 64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) sawValid = 1'b1;
            tick();
        end
        checkOutput("rst_mul_no_valid", 64'(sawValid), 64'd0);
`else
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) sawValid = 1'b1;
            tick();
        end
        checkOutput("rst_done_no_valid", 64'(sawValid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
